// File: rtl/md_unit.sv
// md_unit: MIPS HI/LO multiply-divide unit; Clk/Reset, md_signal+md_control start op on A/B, busy/done status, res_hi/res_lo results
module md_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        md_signal,
  input  logic [2:0]  md_control,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] a_q, amag_q, bmag_q, rem_q, quo_q, hi_q, lo_q;
  logic [63:0] acc_q;
  logic        neg_q, sa_q, bzero_q, busy_q, done_q;
  logic        signed_op, sa, sb;
  logic [31:0] amag, bmag, rem_d, quo_d, q_fin, r_fin;
  logic [7:0]  b_byte;
  logic [39:0] pp;
  logic [63:0] acc_d, mul_res;
  logic [32:0] rs, diff;
  always_comb begin
    signed_op = (md_control == 3'd0) || (md_control == 3'd2);
    sa        = signed_op & A[31];
    sb        = signed_op & B[31];
    amag      = sa ? -A : A;
    bmag      = sb ? -B : B;
    b_byte    = bmag_q[{cnt_q[1:0], 3'b000} +: 8];
    pp        = {8'b0, amag_q} * {32'b0, b_byte};
    acc_d     = acc_q + ({24'b0, pp} << {cnt_q[1:0], 3'b000});
    mul_res   = neg_q ? -acc_d : acc_d;
    rs        = {rem_q, quo_q[31]};
    diff      = rs - {1'b0, bmag_q};
    rem_d     = diff[32] ? rs[31:0] : diff[31:0];
    quo_d     = {quo_q[30:0], ~diff[32]};
    q_fin     = bzero_q ? 32'hFFFFFFFF : (neg_q ? -quo_d : quo_d);
    r_fin     = bzero_q ? a_q : (sa_q ? -rem_d : rem_d);
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      amag_q  <= '0;
      bmag_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      bzero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (md_signal) begin
            case (md_control)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                state_q <= md_control[1] ? DIV : MUL;
                busy_q  <= 1'b1;
                cnt_q   <= '0;
                a_q     <= A;
                amag_q  <= amag;
                bmag_q  <= bmag;
                neg_q   <= sa ^ sb;
                sa_q    <= sa;
                bzero_q <= (B == 32'd0);
                acc_q   <= '0;
                rem_q   <= '0;
                quo_q   <= amag;
              end
              3'd4: hi_q <= A;
              3'd5: lo_q <= A;
              default: ;
            endcase
          end
        end
        MUL: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd3) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            hi_q    <= mul_res[63:32];
            lo_q    <= mul_res[31:0];
          end
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            hi_q    <= r_fin;
            lo_q    <= q_fin;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign res_hi = hi_q;
  assign res_lo = lo_q;
endmodule
